free_list_allocator: RTL and testbench

Parametrised multi-port allocator over a bitmap of `NUM_ENTRIES` free/busy slots: physical registers, load/store queue entries, MSHRs. Each cycle it grants up to `ALLOC_PORTS` distinct free slot indices, picked by a multi-hit priority scan: fixed low-first, fixed high-first, or round-robin from a rotating pointer. It also accepts one slot release per cycle. It sits between the rename/dispatch stage and the structure whose slots it tracks, and owns the only copy of the free bitmap.

---
 rtl/free_list_allocator.sv | 118 +++++++++++
 tb/tb_free_list_allocator.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/free_list_allocator.sv
// Multi-port free-slot allocator over a free/busy bitmap. Grants up to ALLOC_PORTS distinct
// free indices per cycle in a low-first, high-first or round-robin scan, and takes one release per cycle.
module free_list_allocator #(
    parameter int NUM_ENTRIES   = 32,
    parameter int ALLOC_PORTS   = 2,
    parameter int HIGH_PRIORITY = 0,
    parameter int ROUND_ROBIN   = 0,
    localparam int IDXW         = $clog2(NUM_ENTRIES)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [ALLOC_PORTS-1:0]                alloc_req,
    output logic [ALLOC_PORTS-1:0]                alloc_gnt,
    output logic [ALLOC_PORTS-1:0][IDXW-1:0]      alloc_idx,
    input  logic                                  free_valid,
    input  logic [IDXW-1:0]                       free_idx,
    output logic [IDXW:0]                         free_count,
    output logic                                  none_free,
    output logic                                  all_free,
    output logic                                  dbl_free_err
);

    localparam logic [IDXW:0] FULL_CNT = (IDXW+1)'(NUM_ENTRIES);
    localparam logic [IDXW:0] ONE_CNT  = (IDXW+1)'(1);
    localparam logic [IDXW-1:0] ONE_IDX = IDXW'(1);

    logic [NUM_ENTRIES-1:0] free_map_q, free_map_d;
    logic [IDXW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDXW:0]          free_count_q, free_count_d;
    logic                   dbl_free_err_q, dbl_free_err_d;

    // Position p of the scan visits slot pos_slot[p]; scan_map is the bitmap in scan order.
    logic [IDXW-1:0]        pos_slot [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] scan_map;

    for (genvar p = 0; p < NUM_ENTRIES; p++) begin : g_order
        if (ROUND_ROBIN != 0) begin : g_rr
            // N is a power of two, so the IDXW-bit add wraps modulo N.
            assign pos_slot[p] = rr_ptr_q + IDXW'(p);
        end else if (HIGH_PRIORITY != 0) begin : g_high
            assign pos_slot[p] = IDXW'(NUM_ENTRIES - 1 - p);
        end else begin : g_low
            assign pos_slot[p] = IDXW'(p);
        end
        assign scan_map[p] = free_map_q[pos_slot[p]];
    end

    // Request/grant contract: alloc_gnt[i] answers alloc_req[i] in the same cycle and the
    // slot in alloc_idx[i] is owned by the requester from the next edge; there is no stall.
    logic [NUM_ENTRIES-1:0] taken;
    logic                   found;
    logic                   any_gnt;
    logic [IDXW-1:0]        last_slot;
    logic [IDXW:0]          n_gnt;

    always_comb begin
        taken     = '0;
        found     = 1'b0;
        any_gnt   = 1'b0;
        last_slot = '0;
        n_gnt     = '0;
        alloc_gnt = '0;
        alloc_idx = '0;
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            found = 1'b0;
            for (int p = 0; p < NUM_ENTRIES; p++) begin
                if (alloc_req[i] && !found && scan_map[p] && !taken[p]) begin
                    found        = 1'b1;
                    taken[p]     = 1'b1;
                    alloc_gnt[i] = 1'b1;
                    alloc_idx[i] = pos_slot[p];
                    last_slot    = pos_slot[p];
                    any_gnt      = 1'b1;
                    n_gnt        = n_gnt + ONE_CNT;
                end
            end
        end
    end

    logic release_ok;

    always_comb begin
        release_ok     = free_valid && !free_map_q[free_idx];
        free_map_d     = free_map_q;
        dbl_free_err_d = dbl_free_err_q | (free_valid && free_map_q[free_idx]);
        if (release_ok) begin
            free_map_d[free_idx] = 1'b1;
        end
        // A released slot was busy, so it can never collide with a grant this cycle.
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            if (alloc_gnt[i]) begin
                free_map_d[alloc_idx[i]] = 1'b0;
            end
        end
        free_count_d = free_count_q - n_gnt + (release_ok ? ONE_CNT : '0);
        rr_ptr_d     = any_gnt ? last_slot + ONE_IDX : rr_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_map_q     <= '1;
            rr_ptr_q       <= '0;
            free_count_q   <= FULL_CNT;
            dbl_free_err_q <= 1'b0;
        end else begin
            free_map_q     <= free_map_d;
            rr_ptr_q       <= rr_ptr_d;
            free_count_q   <= free_count_d;
            dbl_free_err_q <= dbl_free_err_d;
        end
    end

    assign free_count   = free_count_q;
    assign none_free    = (free_count_q == '0);
    assign all_free     = (free_count_q == FULL_CNT);
    assign dbl_free_err = dbl_free_err_q;

endmodule

// File: tb/tb_free_list_allocator.sv
// Bench for free_list_allocator: low-first, high-first and round-robin instances share one
// stimulus stream and are each checked against a queue-based model of the scan rules.
module tb_free_list_allocator;

    localparam int N  = 8;
    localparam int P  = 2;
    localparam int W  = 3;
    localparam int NM = 3;   // mode 0 = low, 1 = high, 2 = round-robin

    logic         clk = 1'b0;
    logic         rst;
    logic [P-1:0] alloc_req;
    logic         free_valid;
    logic [W-1:0] free_idx;

    logic [P-1:0]        gnt_w  [NM];
    logic [P-1:0][W-1:0] idx_w  [NM];
    logic [W:0]          cnt_w  [NM];
    logic                none_w [NM];
    logic                all_w  [NM];
    logic                err_w  [NM];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NM; g++) begin : g_dut
        free_list_allocator #(
            .NUM_ENTRIES  (N),
            .ALLOC_PORTS  (P),
            .HIGH_PRIORITY((g == 1) ? 1 : 0),
            .ROUND_ROBIN  ((g == 2) ? 1 : 0)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .alloc_req   (alloc_req),
            .alloc_gnt   (gnt_w[g]),
            .alloc_idx   (idx_w[g]),
            .free_valid  (free_valid),
            .free_idx    (free_idx),
            .free_count  (cnt_w[g]),
            .none_free   (none_w[g]),
            .all_free    (all_w[g]),
            .dbl_free_err(err_w[g])
        );
    end

    // Reference model state
    bit           m_free [NM][N];
    int           m_rr   [NM];
    int           m_cnt  [NM];
    bit           m_err  [NM];
    bit           e_gnt  [NM][P];
    int           e_idx  [NM][P];
    logic [W-1:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < NM; m++) begin
            for (int s = 0; s < N; s++) m_free[m][s] = 1'b1;
            m_rr[m]  = 0;
            m_cnt[m] = N;
            m_err[m] = 1'b0;
        end
    endtask

    // Free slots listed in scan order; the k-th requester takes the k-th entry.
    task automatic predict();
        int s;
        for (int m = 0; m < NM; m++) begin
            exp_q.delete();
            for (int p = 0; p < N; p++) begin
                s = (m == 0) ? p : (m == 1) ? (N - 1 - p) : ((m_rr[m] + p) % N);
                if (m_free[m][s]) exp_q.push_back(W'(s));
            end
            for (int i = 0; i < P; i++) begin
                e_gnt[m][i] = 1'b0;
                e_idx[m][i] = 0;
                if (alloc_req[i] && exp_q.size() > 0) begin
                    e_gnt[m][i] = 1'b1;
                    e_idx[m][i] = int'(exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic check_models();
        for (int m = 0; m < NM; m++) begin
            for (int i = 0; i < P; i++) begin
                check_val($sformatf("m%0d_gnt%0d", m, i), 32'(gnt_w[m][i]), 32'(e_gnt[m][i]));
                check_val($sformatf("m%0d_idx%0d", m, i), 32'(idx_w[m][i]), 32'(e_idx[m][i]));
            end
            check_val($sformatf("m%0d_count", m), 32'(cnt_w[m]), 32'(m_cnt[m]));
            check_val($sformatf("m%0d_none", m), 32'(none_w[m]), 32'(m_cnt[m] == 0));
            check_val($sformatf("m%0d_all", m), 32'(all_w[m]), 32'(m_cnt[m] == N));
            check_val($sformatf("m%0d_dbl", m), 32'(err_w[m]), 32'(m_err[m]));
        end
    endtask

    task automatic commit();
        for (int m = 0; m < NM; m++) begin
            if (free_valid) begin
                if (m_free[m][free_idx]) begin
                    m_err[m] = 1'b1;
                end else begin
                    m_free[m][free_idx] = 1'b1;
                    m_cnt[m]++;
                end
            end
            for (int i = 0; i < P; i++) begin
                if (e_gnt[m][i]) begin
                    m_free[m][e_idx[m][i]] = 1'b0;
                    m_cnt[m]--;
                    m_rr[m] = (e_idx[m][i] + 1) % N;
                end
            end
        end
    endtask

    task automatic apply(input logic [P-1:0] req, input logic fv, input logic [W-1:0] fidx);
        alloc_req  = req;
        free_valid = fv;
        free_idx   = fidx;
        #1;
        predict();
        check_models();
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        alloc_req  = '0;
        free_valid = 1'b0;
        free_idx   = '0;
        rst        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    int busy_list[$];
    logic [W-1:0] pick;

    initial begin
        rst = 1'b1;
        alloc_req = '0;
        free_valid = 1'b0;
        free_idx = '0;
        model_reset();
        #12;
        @(negedge clk);
        rst = 1'b0;

        // Reset state and fixed-low fill
        apply(2'b00, 1'b0, 3'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            apply(2'b11, 1'b0, 3'd0);
            check_val("low_basic_p0", 32'(idx_w[0][0]), 32'(2 * k));
            check_val("low_basic_p1", 32'(idx_w[0][1]), 32'(2 * k + 1));
            tick();
        end
        apply(2'b11, 1'b0, 3'd0);
        check_val("low_cnt2", 32'(cnt_w[0]), 32'd2);
        check_val("low_last_p0", 32'(idx_w[0][0]), 32'd6);
        check_val("low_last_p1", 32'(idx_w[0][1]), 32'd7);
        tick();
        apply(2'b00, 1'b0, 3'd0);
        check_val("low_none", 32'(none_w[0]), 32'd1);
        check_val("low_cnt0", 32'(cnt_w[0]), 32'd0);
        tick();

        // Partial grant with only slot 5 free, then exhaustion
        apply(2'b00, 1'b1, 3'd5);
        tick();
        apply(2'b11, 1'b0, 3'd0);
        for (int m = 0; m < NM; m++) begin
            check_val("partial_gnt", 32'(gnt_w[m]), 32'd1);
            check_val("partial_idx", 32'(idx_w[m][0]), 32'd5);
        end
        tick();
        apply(2'b11, 1'b0, 3'd0);
        check_val("exhaust_gnt", 32'(gnt_w[0]), 32'd0);
        tick();
        apply(2'b00, 1'b0, 3'd0);
        check_val("exhaust_cnt", 32'(cnt_w[0]), 32'd0);
        tick();

        // Release 6 while the only free slot 3 is granted
        apply(2'b00, 1'b1, 3'd3);
        tick();
        apply(2'b11, 1'b1, 3'd6);
        check_val("simul_gnt", 32'(gnt_w[0]), 32'd1);
        check_val("simul_idx", 32'(idx_w[0][0]), 32'd3);
        tick();
        apply(2'b01, 1'b0, 3'd0);
        check_val("simul_cnt", 32'(cnt_w[0]), 32'd1);
        check_val("simul_next", 32'(idx_w[0][0]), 32'd6);
        tick();

        // Double free of slot 4, then asynchronous reset between edges
        apply(2'b00, 1'b1, 3'd4);
        tick();
        apply(2'b00, 1'b1, 3'd4);
        tick();
        apply(2'b00, 1'b0, 3'd0);
        check_val("dbl_err", 32'(err_w[0]), 32'd1);
        check_val("dbl_cnt", 32'(cnt_w[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        for (int m = 0; m < NM; m++) begin
            check_val("async_cnt", 32'(cnt_w[m]), 32'd8);
            check_val("async_all", 32'(all_w[m]), 32'd1);
            check_val("async_dbl", 32'(err_w[m]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Sparse request: high-first gives port1 slot 7, low-first gives port1 slot 0
        apply(2'b10, 1'b0, 3'd0);
        check_val("high_sparse_gnt", 32'(gnt_w[1]), 32'd2);
        check_val("high_sparse_idx", 32'(idx_w[1][1]), 32'd7);
        check_val("high_sparse_p0", 32'(idx_w[1][0]), 32'd0);
        check_val("low_sparse_idx", 32'(idx_w[0][1]), 32'd0);
        tick();

        // Round-robin pointer keeps moving past a just-released slot and wraps
        do_reset();
        apply(2'b11, 1'b0, 3'd0);
        tick();
        apply(2'b00, 1'b1, 3'd0);
        tick();
        apply(2'b01, 1'b0, 3'd0);
        check_val("rr_skip", 32'(idx_w[2][0]), 32'd2);
        check_val("low_reuse", 32'(idx_w[0][0]), 32'd0);
        tick();
        for (int k = 3; k < 8; k++) begin
            apply(2'b01, 1'b0, 3'd0);
            check_val("rr_seq", 32'(idx_w[2][0]), 32'(k));
            tick();
        end
        apply(2'b01, 1'b0, 3'd0);
        check_val("rr_wrap", 32'(idx_w[2][0]), 32'd0);
        tick();

        // Randomized traffic, releases biased toward busy slots of the low-first instance
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end
            busy_list.delete();
            for (int s = 0; s < N; s++) if (!m_free[0][s]) busy_list.push_back(s);
            if (busy_list.size() > 0 && $urandom_range(0, 3) != 0)
                pick = W'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
            else
                pick = W'($urandom_range(0, N - 1));
            apply(P'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
